// File: rtl/rv151_rgf_wbctl.sv
// Register-file write-port arbiter (writeback A vs load return B) plus load scoreboard.
// Optional macro RV151_RGF_WBCTL_FWD_EN enables same-cycle forwarding of rgf_wd to decode.
module rv151_rgf_wbctl #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned MAX_OUT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_wa,
  input  logic [31:0] a_wd,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_wa,
  input  logic [31:0] b_wd,
  output logic        b_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        iss_ready,
  input  logic [4:0]  qa1,
  input  logic [4:0]  qa2,
  output logic        busy1,
  output logic        busy2,
  output logic        fwd1_hit,
  output logic        fwd2_hit,
  output logic        rgf_we,
  output logic [4:0]  rgf_wa,
  output logic [31:0] rgf_wd,
  output logic        err
);

  logic [31:0] pending_q, pending_d;
  logic [3:0]  starve_q, starve_d;
  logic [4:0]  out_q, out_d;
  logic        err_q, err_d;

  logic starve_hit, a_acc, b_acc, iss_acc, iss_trk, clr_same;

  always_comb begin
    starve_hit = (starve_q == 4'(STARVE_MAX));
    a_ready    = ~(b_valid & starve_hit);
    b_ready    = ~a_valid | starve_hit;
    a_acc      = a_valid & a_ready;
    b_acc      = b_valid & b_ready;
    // a_acc and b_acc are mutually exclusive, so B-first muxing is a plain select
    rgf_wa     = b_acc ? b_wa : a_wa;
    rgf_wd     = b_acc ? b_wd : a_wd;
    rgf_we     = (a_acc | b_acc) & (rgf_wa != '0);
    clr_same   = b_acc & (b_wa == iss_rd);
    iss_ready  = (~pending_q[iss_rd] | clr_same) & ((out_q < 5'(MAX_OUT)) | b_acc);
    iss_acc    = iss_valid & iss_ready;
    iss_trk    = iss_acc & (iss_rd != '0);
  end

`ifdef RV151_RGF_WBCTL_FWD_EN
  assign fwd1_hit = rgf_we & (rgf_wa == qa1);
  assign fwd2_hit = rgf_we & (rgf_wa == qa2);
`else
  assign fwd1_hit = 1'b0;
  assign fwd2_hit = 1'b0;
`endif

  assign busy1 = (qa1 != '0) & pending_q[qa1] & ~fwd1_hit;
  assign busy2 = (qa2 != '0) & pending_q[qa2] & ~fwd2_hit;
  assign err   = err_q;

  always_comb begin
    pending_d = pending_q;
    starve_d  = starve_q;
    out_d     = out_q;
    err_d     = err_q;
    if (b_acc) begin
      starve_d = '0;
    end else if (b_valid & ~starve_hit) begin
      starve_d = starve_q + 4'd1;
    end
    if (b_acc & (b_wa != '0) & ~pending_q[b_wa]) begin
      err_d = 1'b1;
    end
    // clear before set so a same-cycle re-issue of the returning register stays pending
    if (b_acc) begin
      pending_d[b_wa] = 1'b0;
    end
    if (iss_trk) begin
      pending_d[iss_rd] = 1'b1;
    end
    if (iss_trk & ~b_acc) begin
      out_d = out_q + 5'd1;
    end else if (~iss_trk & b_acc & (out_q != '0)) begin
      out_d = out_q - 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      starve_q  <= '0;
      out_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      starve_q  <= starve_d;
      out_q     <= out_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_rv151_rgf_wbctl.sv
// Self-checking bench for rv151_rgf_wbctl: directed vector table, corner sequences, random vs model.
module tb_rv151_rgf_wbctl;
  localparam int unsigned SM = 4;
  localparam int unsigned MO = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, iss_valid;
  logic [4:0]  a_wa, b_wa, iss_rd, qa1, qa2;
  logic [31:0] a_wd, b_wd;
  logic        a_ready, b_ready, iss_ready, busy1, busy2, fwd1_hit, fwd2_hit;
  logic        rgf_we, err;
  logic [4:0]  rgf_wa;
  logic [31:0] rgf_wd;

  rv151_rgf_wbctl #(.STARVE_MAX(SM), .MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_wa(a_wa), .a_wd(a_wd), .a_ready(a_ready),
    .b_valid(b_valid), .b_wa(b_wa), .b_wd(b_wd), .b_ready(b_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .qa1(qa1), .qa2(qa2), .busy1(busy1), .busy2(busy2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .rgf_we(rgf_we), .rgf_wa(rgf_wa), .rgf_wd(rgf_wd), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    a_valid = 0; a_wa = 0; a_wd = 0;
    b_valid = 0; b_wa = 0; b_wd = 0;
    iss_valid = 0; iss_rd = 0; qa1 = 0; qa2 = 0;
  endtask

  // inputs are applied 1 time unit after posedge; outputs sampled 3 units later
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; idle();
    next_cycle();
    rst = 0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit av; logic [4:0] awa; logic [31:0] awd;
    bit bv; logic [4:0] bwa; logic [31:0] bwd;
    bit iv; logic [4:0] ird; logic [4:0] q1; logic [4:0] q2;
    bit we; logic [4:0] wa; logic [31:0] wd;
    bit ar; bit br; bit ir; bit b1; bit b2; bit er;
  } vec_t;
  vec_t tbl [10];

  function automatic vec_t mk(bit av, logic [4:0] awa, logic [31:0] awd,
                              bit bv, logic [4:0] bwa, logic [31:0] bwd,
                              bit iv, logic [4:0] ird, logic [4:0] q1, logic [4:0] q2,
                              bit we, logic [4:0] wa, logic [31:0] wd,
                              bit ar, bit br, bit ir, bit b1, bit b2, bit er);
    vec_t v;
    v.av = av; v.awa = awa; v.awd = awd; v.bv = bv; v.bwa = bwa; v.bwd = bwd;
    v.iv = iv; v.ird = ird; v.q1 = q1; v.q2 = q2;
    v.we = we; v.wa = wa; v.wd = wd; v.ar = ar; v.br = br; v.ir = ir;
    v.b1 = b1; v.b2 = b2; v.er = er;
    return v;
  endfunction

  // ---------------- reference model ----------------
  bit pend [32];
  int starve, outc;
  bit merr;
  bit e_ar, e_br, e_ir, e_we, e_b1, e_b2, e_f1, e_f2, aacc, bacc, iacc;
  logic [4:0]  g_wa;
  logic [31:0] g_wd;

  task automatic model_reset();
    foreach (pend[i]) pend[i] = 0;
    starve = 0; outc = 0; merr = 0;
  endtask

  task automatic model_eval();
    bit hit;
    hit  = (starve == int'(SM));
    e_ar = !(b_valid && hit);
    e_br = !a_valid || hit;
    aacc = a_valid && e_ar;
    bacc = b_valid && e_br;
    g_wa = bacc ? b_wa : a_wa;
    g_wd = bacc ? b_wd : a_wd;
    e_we = (aacc || bacc) && (g_wa != 0);
    e_ir = (!pend[iss_rd] || (bacc && b_wa == iss_rd)) && (outc < int'(MO) || bacc);
    iacc = iss_valid && e_ir;
`ifdef RV151_RGF_WBCTL_FWD_EN
    e_f1 = e_we && (g_wa == qa1);
    e_f2 = e_we && (g_wa == qa2);
`else
    e_f1 = 0;
    e_f2 = 0;
`endif
    e_b1 = (qa1 != 0) && pend[qa1] && !e_f1;
    e_b2 = (qa2 != 0) && pend[qa2] && !e_f2;
  endtask

  task automatic model_step();
    bit trk;
    trk = iacc && (iss_rd != 0);
    if (bacc && b_wa != 0 && !pend[b_wa]) merr = 1;
    if (bacc) starve = 0;
    else if (b_valid) starve = (starve + 1 > int'(SM)) ? int'(SM) : starve + 1;
    if (bacc) pend[b_wa] = 0;
    if (trk) pend[iss_rd] = 1;
    if (trk && !bacc) outc++;
    else if (!trk && bacc && outc > 0) outc--;
  endtask

  task automatic check_model(input int n);
    model_eval();
    chk($sformatf("rnd%0d_we", n), rgf_we, e_we);
    if (e_we) begin
      chk($sformatf("rnd%0d_wa", n), rgf_wa, g_wa);
      chk($sformatf("rnd%0d_wd", n), rgf_wd, g_wd);
    end
    chk($sformatf("rnd%0d_rdy", n), {a_ready, b_ready, iss_ready}, {e_ar, e_br, e_ir});
    chk($sformatf("rnd%0d_busy", n), {busy1, busy2, fwd1_hit, fwd2_hit}, {e_b1, e_b2, e_f1, e_f2});
    chk($sformatf("rnd%0d_err", n), err, merr);
  endtask

  initial begin
    rst = 1; idle();
    repeat (2) next_cycle();
    #3;
    chk("rst_outs", {rgf_we, a_ready, b_ready, iss_ready, busy1, busy2, fwd1_hit, fwd2_hit, err},
        9'b0_111_0000_0);
    next_cycle();
    rst = 0;

    tbl[0] = mk(1,5,32'hDEADBEEF, 0,0,0, 0,0,0,0,  1,5,32'hDEADBEEF, 1,0,1,0,0,0);
    tbl[1] = mk(1,0,32'h1234,     0,0,0, 0,0,0,0,  0,0,0,           1,0,1,0,0,0);
    tbl[2] = mk(0,0,0,            0,0,0, 1,7,0,0,  0,0,0,           1,1,1,0,0,0);
    tbl[3] = mk(0,0,0,            0,0,0, 1,7,7,0,  0,0,0,           1,1,0,1,0,0);
    tbl[4] = mk(0,0,0,            1,7,77,1,7,0,0,  1,7,77,          1,1,1,0,0,0);
    tbl[5] = mk(0,0,0,            0,0,0, 1,4,7,0,  0,0,0,           1,1,1,1,0,0);
    tbl[6] = mk(0,0,0,            0,0,0, 1,3,0,0,  0,0,0,           1,1,0,0,0,0);
    tbl[7] = mk(0,0,0,            1,4,44,1,3,0,0,  1,4,44,          1,1,1,0,0,0);
    tbl[8] = mk(0,0,0,            1,9,99,0,0,0,0,  1,9,99,          1,1,1,0,0,0);
    tbl[9] = mk(0,0,0,            0,0,0, 0,0,0,3,  0,0,0,           1,1,1,0,1,1);
    for (int i = 0; i < 10; i++) begin
      a_valid = tbl[i].av; a_wa = tbl[i].awa; a_wd = tbl[i].awd;
      b_valid = tbl[i].bv; b_wa = tbl[i].bwa; b_wd = tbl[i].bwd;
      iss_valid = tbl[i].iv; iss_rd = tbl[i].ird; qa1 = tbl[i].q1; qa2 = tbl[i].q2;
      #3;
      chk($sformatf("tbl%0d_we", i), rgf_we, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("tbl%0d_wa", i), rgf_wa, tbl[i].wa);
        chk($sformatf("tbl%0d_wd", i), rgf_wd, tbl[i].wd);
      end
      chk($sformatf("tbl%0d_rdy", i), {a_ready, b_ready, iss_ready}, {tbl[i].ar, tbl[i].br, tbl[i].ir});
      chk($sformatf("tbl%0d_busy", i), {busy1, busy2}, {tbl[i].b1, tbl[i].b2});
      chk($sformatf("tbl%0d_err", i), err, tbl[i].er);
      next_cycle();
    end

    // mid-operation reset clears pending and err at once; a stale return then flags err
    idle(); iss_valid = 1; iss_rd = 6;
    next_cycle();
    idle(); qa1 = 6; #3;
    chk("mr_busy_before", busy1, 1);
    rst = 1; #1;
    chk("mr_async", {busy1, err, iss_ready}, 3'b001);
    next_cycle();
    rst = 0;
    b_valid = 1; b_wa = 6; b_wd = 32'h66; #3;
    chk("mr_stale_we", {b_ready, rgf_we, rgf_wa}, {2'b11, 5'd6});
    next_cycle();
    idle(); #3;
    chk("mr_stale_err", err, 1);
    next_cycle();

    // starvation: B granted on cycles 4 and 9 only
    do_reset();
    a_valid = 1; a_wa = 1; a_wd = 32'hA; b_valid = 1; b_wa = 2; b_wd = 32'hB;
    for (int c = 0; c < 11; c++) begin
      #3;
      chk($sformatf("stv%0d_bready", c), b_ready, (c == 4 || c == 9));
      chk($sformatf("stv%0d_wa", c), rgf_wa, (c == 4 || c == 9) ? 5'd2 : 5'd1);
      next_cycle();
    end

    // forwarding / busy release on load return
    do_reset();
    iss_valid = 1; iss_rd = 3;
    next_cycle();
    idle(); b_valid = 1; b_wa = 3; b_wd = 32'h33; qa2 = 3; #3;
`ifdef RV151_RGF_WBCTL_FWD_EN
    chk("fwd_ret", {fwd2_hit, busy2}, 2'b10);
`else
    chk("fwd_ret", {fwd2_hit, busy2}, 2'b01);
`endif
    next_cycle();
    idle(); qa2 = 3; #3;
    chk("fwd_after", {fwd2_hit, busy2}, 2'b00);
    next_cycle();

    // randomized traffic against the model
    do_reset();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      a_valid = ($urandom_range(0, 2) != 0);
      a_wa = 5'($urandom_range(0, 7)); a_wd = $urandom;
      b_valid = ($urandom_range(0, 2) != 0);
      b_wa = 5'($urandom_range(0, 7)); b_wd = $urandom;
      iss_valid = ($urandom_range(0, 1) != 0);
      iss_rd = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      qa1 = 5'($urandom_range(0, 7)); qa2 = 5'($urandom_range(0, 7));
      #3;
      check_model(n);
      @(posedge clk);
      model_step();
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
